seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed 7-segment driver for the clock display. It takes the binary time fields (hours, minutes, seconds), snapshots them once per scan frame and converts each field to two BCD digits. It scans NUM_DIGITS common-electrode digits with an anti-ghosting blank interval, colon blink, leading-zero suppression and out-of-range dash display. It sits between the timekeeping counters and the board's segment and digit pins.

---
 rtl/seg7_pkg.sv | 58 +++++
 rtl/seg7_scan_driver_if.sv | 23 ++
 rtl/seg7_bcd_split.sv | 34 +++
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns, digit positions and digit-code type for the 7-segment scan driver.
// Pure constants/functions: no latency, no flow control.
package seg7_pkg;

    // Patterns are {dp,g,f,e,d,c,b,a}, active-high; dp is never set here.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    localparam int SEG_DP_BIT = 7;

    // Digit positions in the full six-digit order; a four-digit display starts at POS_M1.
    localparam logic [2:0] POS_S1  = 3'd0;
    localparam logic [2:0] POS_S10 = 3'd1;
    localparam logic [2:0] POS_M1  = 3'd2;
    localparam logic [2:0] POS_M10 = 3'd3;
    localparam logic [2:0] POS_H1  = 3'd4;
    localparam logic [2:0] POS_H10 = 3'd5;

    typedef struct packed {
        logic [3:0] val;
        logic       blank;
        logic       dash;
    } digit_code_t;

    function automatic logic [7:0] seg_encode(input digit_code_t code);
        logic [7:0] pat;
        pat = SEG_BLANK;
        if (code.dash) begin
            pat = SEG_DASH;
        end else if (!code.blank) begin
            case (code.val)
                4'd0:    pat = SEG_0;
                4'd1:    pat = SEG_1;
                4'd2:    pat = SEG_2;
                4'd3:    pat = SEG_3;
                4'd4:    pat = SEG_4;
                4'd5:    pat = SEG_5;
                4'd6:    pat = SEG_6;
                4'd7:    pat = SEG_7;
                4'd8:    pat = SEG_8;
                4'd9:    pat = SEG_9;
                default: pat = SEG_BLANK;
            endcase
        end
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Time-field inputs and pin-level outputs of the 7-segment scan driver.
// Plain wires: no latency, no flow control (the display side never stalls).
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 6
);
    logic [5:0]            seconds;
    logic [5:0]            minutes;
    logic [4:0]            hours;
    logic                  enable;
    logic [7:0]            segment_out;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  frame_start;

    modport master (
        output seconds, minutes, hours, enable,
        input  segment_out, digit_en, frame_start
    );

    modport slave (
        input  seconds, minutes, hours, enable,
        output segment_out, digit_en, frame_start
    );
endinterface

// File: rtl/seg7_bcd_split.sv
// Combinational 6-bit binary to two BCD digits by compare-subtract, plus a range flag against MAX.
// Zero latency, no flow control.
module seg7_bcd_split #(
    parameter int MAX = 59
) (
    input  logic [5:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       out_of_range
);

    logic [5:0] rem;

    // Three weighted steps (40/20/10) cover the whole 0..63 input range.
    always_comb begin
        rem  = value;
        tens = 4'd0;
        if (rem >= 6'd40) begin
            rem  = rem - 6'd40;
            tens = tens + 4'd4;
        end
        if (rem >= 6'd20) begin
            rem  = rem - 6'd20;
            tens = tens + 4'd2;
        end
        if (rem >= 6'd10) begin
            rem  = rem - 6'd10;
            tens = tens + 4'd1;
        end
        ones         = rem[3:0];
        out_of_range = (value > 6'(MAX));
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: per-frame snapshot, BCD split, blank interval, colon, dashes.
// All pins registered one cycle after cnt/idx; free-running scan, no backpressure.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit HOUR_LZ_BLANK  = 1'b1,
    parameter bit COLON_BLINK    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);

    if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_num_digits
        $error("seg7_scan_driver: NUM_DIGITS must be 4 or 6");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg7_scan_driver: SCAN_DIV must be at least 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
        $error("seg7_scan_driver: BLANK_CYCLES must be below SCAN_DIV");
    end

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [2:0]            POS_OFFSET = (NUM_DIGITS == 6) ? 3'd0 : 3'd2;
    localparam logic [7:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  started;
    logic [5:0]            snap_sec;
    logic [5:0]            snap_min;
    logic [4:0]            snap_hr;
    logic                  frame_start_q;
    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_q;

    logic                  cnt_wrap;
    logic                  idx_wrap;
    logic                  snap_load;
    logic                  lit;
    logic [2:0]            pos;
    logic                  dp_on;
    digit_code_t           code;
    logic [7:0]            seg_lvl;
    logic [NUM_DIGITS-1:0] dig_sel;

    logic [3:0] sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones;
    logic       sec_oor, min_oor, hr_oor;

    seg7_bcd_split #(.MAX(59)) u_sec_split (
        .value(snap_sec), .tens(sec_tens), .ones(sec_ones), .out_of_range(sec_oor)
    );
    seg7_bcd_split #(.MAX(59)) u_min_split (
        .value(snap_min), .tens(min_tens), .ones(min_ones), .out_of_range(min_oor)
    );
    seg7_bcd_split #(.MAX(23)) u_hr_split (
        .value({1'b0, snap_hr}), .tens(hr_tens), .ones(hr_ones), .out_of_range(hr_oor)
    );

    assign cnt_wrap  = (cnt == CNT_LAST);
    assign idx_wrap  = (idx == IDX_LAST);
    // First cycle out of reset also loads, so frame 0 never shows the cleared snapshot.
    assign snap_load = !started || (cnt_wrap && idx_wrap);

    always_comb begin
        code       = '0;
        code.blank = 1'b1;
        pos        = 3'(idx) + POS_OFFSET;
        case (pos)
            POS_S1:  begin code.val = sec_ones; code.blank = 1'b0; code.dash = sec_oor; end
            POS_S10: begin code.val = sec_tens; code.blank = 1'b0; code.dash = sec_oor; end
            POS_M1:  begin code.val = min_ones; code.blank = 1'b0; code.dash = min_oor; end
            POS_M10: begin code.val = min_tens; code.blank = 1'b0; code.dash = min_oor; end
            POS_H1:  begin code.val = hr_ones;  code.blank = 1'b0; code.dash = hr_oor;  end
            POS_H10: begin
                code.val   = hr_tens;
                code.blank = HOUR_LZ_BLANK && (hr_tens == 4'd0) && !hr_oor;
                code.dash  = hr_oor;
            end
            default: code.blank = 1'b1;
        endcase

        dp_on = ((pos == POS_H1) || ((pos == POS_M1) && (NUM_DIGITS == 6)))
                && (COLON_BLINK ? ~snap_sec[0] : 1'b1);

        seg_lvl             = seg_encode(code);
        seg_lvl[SEG_DP_BIT] = dp_on;

        dig_sel = NUM_DIGITS'(1) << idx;
        lit     = bus.enable && (cnt >= BLANK_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            started       <= 1'b0;
            snap_sec      <= '0;
            snap_min      <= '0;
            snap_hr       <= '0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF;
            dig_q         <= DIG_OFF;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) begin
                idx <= idx_wrap ? '0 : idx + 1'b1;
            end
            started       <= 1'b1;
            frame_start_q <= snap_load;
            if (snap_load) begin
                snap_sec <= bus.seconds;
                snap_min <= bus.minutes;
                snap_hr  <= bus.hours;
            end
            seg_q <= (lit ? seg_lvl : 8'h00) ^ SEG_OFF;
            dig_q <= (lit ? dig_sel : '0) ^ DIG_OFF;
        end
    end

    assign bus.segment_out = seg_q;
    assign bus.digit_en    = dig_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (6 digits, SCAN_DIV=8, BLANK_CYCLES=2): directed and random time values
// checked every cycle against a frame/slot arithmetic model of the display.
module tb_seg7_scan_driver;

    localparam int ND    = 6;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1),
        .HOUR_LZ_BLANK(1'b1), .COLON_BLINK(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n        = 0;
    int snap_h   = 0;
    int snap_m   = 0;
    int snap_s   = 0;

    logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Active-high pattern for slot 0..5 = s1, s10, m1, m10, h1, h10.
    function automatic logic [7:0] digit_pattern(int h, int m, int s, int slot);
        int         v;
        bit         dash;
        logic [7:0] p;
        case (slot)
            0:       begin v = s % 10; dash = (s > 59); end
            1:       begin v = s / 10; dash = (s > 59); end
            2:       begin v = m % 10; dash = (m > 59); end
            3:       begin v = m / 10; dash = (m > 59); end
            4:       begin v = h % 10; dash = (h > 23); end
            default: begin v = h / 10; dash = (h > 23); end
        endcase
        if (dash)                    p = 8'h40;
        else if (slot == 5 && v == 0) p = 8'h00;
        else                          p = tbl[v];
        if ((slot == 2 || slot == 4) && (s % 2 == 0)) p[7] = 1'b1;
        return p;
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at n=%0d: got %h, expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        bit         r, en;
        int         h, m, s, pos, slot, c;
        logic [7:0] exp_seg, exp_dig;
        logic       exp_fs;
        r  = rst;
        en = bus.enable;
        h  = int'(bus.hours);
        m  = int'(bus.minutes);
        s  = int'(bus.seconds);
        @(posedge clk);
        exp_seg = 8'hFF;
        exp_dig = 8'h3F;
        exp_fs  = 1'b0;
        if (r) begin
            n = 0; snap_h = 0; snap_m = 0; snap_s = 0;
        end else begin
            n++;
            pos  = (n - 1) % FRAME;
            slot = pos / SD;
            c    = pos % SD;
            if (en && c >= BC) begin
                exp_seg = ~digit_pattern(snap_h, snap_m, snap_s, slot);
                exp_dig = {2'b00, ~(6'd1 << slot)};
            end
            exp_fs = (n == 1) || (n % FRAME == 0);
            if (exp_fs) begin
                snap_h = h; snap_m = m; snap_s = s;
            end
        end
        #1;
        check("segment_out", bus.segment_out, exp_seg);
        check("digit_en", {2'b00, bus.digit_en}, exp_dig);
        check("frame_start", {7'd0, bus.frame_start}, {7'd0, exp_fs});
    endtask

    task automatic run(int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic set_time(int h, int m, int s);
        bus.hours   = 5'(h);
        bus.minutes = 6'(m);
        bus.seconds = 6'(s);
    endtask

    initial begin
        bus.enable = 1'b1;
        set_time(12, 34, 56);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(2 * FRAME);

        // Leading-zero hour and zero minute tens.
        set_time(9, 5, 7);
        run(2 * FRAME);

        // Mid-frame rollover must not tear the frame being shown.
        set_time(1, 59, 59);
        run(FRAME + 20);
        set_time(2, 0, 0);
        run(FRAME + 28);

        // Out-of-range minutes and hours show dashes.
        set_time(24, 60, 33);
        run(2 * FRAME);
        set_time(31, 63, 63);
        run(FRAME);

        // Colon blink follows the snapshot's seconds parity.
        for (int f = 0; f < 4; f++) begin
            set_time(10, 20, (f % 2 == 1) ? 41 : 40);
            run(FRAME);
        end

        // Random times and enable, changed on slot boundaries and mid-slot.
        for (int f = 0; f < 25; f++) begin
            for (int sl = 0; sl < ND; sl++) begin
                bus.enable = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 3) != 0)
                        set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
                    else
                        set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
                end
                run($urandom_range(1, SD - 1));
                if ($urandom_range(0, 3) == 0) set_time(bus.hours, bus.minutes, $urandom_range(0, 59));
                run(SD - 0);
            end
        end

        // Reset in slot 3, then one dark slot with enable low.
        bus.enable = 1'b1;
        set_time(18, 47, 22);
        run(((FRAME - (n % FRAME)) + 3 * SD + 4) % FRAME);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        bus.enable = 1'b0;
        run(SD);
        bus.enable = 1'b1;
        run(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
